// File: rtl/axi_ram_fill_pkg.sv
// Shared AXI constants, fill sequencer state type and burst-length helper.
package axi_ram_fill_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } fill_state_t;

  // Beats for the next burst: limited by the words left, the burst cap and
  // the distance to the next 4 KiB boundary (addr_lo is word aligned).
  function automatic logic [8:0] fill_burst_beats(
    input logic [11:0]  addr_lo,
    input logic [31:0]  remaining,
    input logic [8:0]   max_len,
    input int unsigned  strb_shift
  );
    logic [12:0] to_boundary;
    logic [31:0] beats;
    to_boundary = 13'd4096 - {1'b0, addr_lo};
    beats       = 32'(to_boundary >> strb_shift);
    if (remaining < beats) beats = remaining;
    if ({23'd0, max_len} < beats) beats = {23'd0, max_len};
    return 9'(beats);
  endfunction

endpackage

// File: rtl/axi_ram_fill.sv
// Command-driven AXI4 write sequencer: fills a word region with a constant or
// incrementing pattern using INCR bursts, one burst outstanding at a time.
module axi_ram_fill
  import axi_ram_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned FILL_ID       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_pattern,
  input  logic                  cmd_incr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int unsigned STRB_SHIFT = $clog2(STRB_WIDTH);
  localparam logic [8:0]  MAX_BEATS  = 9'(MAX_BURST_LEN);

  fill_state_t           state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  incr_q;
  logic [8:0]            beats_q;
  logic [8:0]            wcnt_q;
  logic                  err_acc_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;

  logic [ADDR_WIDTH-1:0] cmd_addr_al;
  logic [ADDR_WIDTH-1:0] addr_adv;
  logic [ADDR_WIDTH-1:0] rem_adv;
  logic [ADDR_WIDTH-1:0] aw_addr_d;
  logic [ADDR_WIDTH-1:0] aw_rem_d;
  logic [8:0]            beats_d;
  logic                  bresp_bad;
  logic                  unused_bid;

  assign unused_bid = ^m_axi_bid;

  // Geometry of the burst about to be issued: from the new command while
  // idle, otherwise from the address/count advanced past the current burst.
  always_comb begin
    cmd_addr_al = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
    addr_adv    = addr_q + ADDR_WIDTH'(32'(beats_q) << STRB_SHIFT);
    rem_adv     = rem_q - ADDR_WIDTH'(beats_q);
    if (state_q == ST_IDLE) begin
      aw_addr_d = cmd_addr_al;
      aw_rem_d  = cmd_len;
    end else begin
      aw_addr_d = addr_adv;
      aw_rem_d  = rem_adv;
    end
    beats_d   = fill_burst_beats(12'(aw_addr_d), 32'(aw_rem_d), MAX_BEATS, STRB_SHIFT);
    bresp_bad = (m_axi_bresp != AXI_RESP_OKAY);
  end

  // Sequencer FSM: IDLE -> AW -> W -> B -> (AW | IDLE), all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      incr_q    <= 1'b0;
      beats_q   <= '0;
      wcnt_q    <= '0;
      err_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr_al;
            rem_q     <= cmd_len;
            data_q    <= cmd_pattern;
            incr_q    <= cmd_incr;
            err_acc_q <= 1'b0;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              awvalid_q <= 1'b1;
              awaddr_q  <= cmd_addr_al;
              awlen_q   <= 8'(beats_d - 9'd1);
              beats_q   <= beats_d;
              state_q   <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wcnt_q    <= beats_q;
            wlast_q   <= (beats_q == 9'd1);
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (m_axi_wready) begin
            data_q <= data_q + DATA_WIDTH'(incr_q);
            wcnt_q <= wcnt_q - 9'd1;
            // wcnt_q counts beats still to send including the current one
            wlast_q <= (wcnt_q == 9'd2);
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            bready_q  <= 1'b0;
            addr_q    <= addr_adv;
            rem_q     <= rem_adv;
            err_acc_q <= err_acc_q | bresp_bad;
            if (rem_adv == '0) begin
              done_q  <= 1'b1;
              err_q   <= err_acc_q | bresp_bad;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              awvalid_q <= 1'b1;
              awaddr_q  <= addr_adv;
              awlen_q   <= 8'(beats_d - 9'd1);
              beats_q   <= beats_d;
              state_q   <= ST_AW;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign m_axi_awid    = ID_WIDTH'(FILL_ID);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(STRB_SHIFT);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_ram_fill.sv
// Bench for axi_ram_fill: behavioural AXI write slave with random stalls and
// a burst/memory reference model computed from the fill rules.
module tb_axi_ram_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] cmd_pattern;
  logic        cmd_incr;
  logic        busy, done, err;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  axi_ram_fill #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4),
    .ID_WIDTH(8), .MAX_BURST_LEN(16), .FILL_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_pattern(cmd_pattern), .cmd_incr(cmd_incr),
    .busy(busy), .done(done), .err(err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Shared with the slave: main process writes these, slave only reads them.
  int unsigned stall_pct = 0;
  int          err_abs   = -1;
  int unsigned cur_seq   = 0;

  // Slave-owned state: main process only reads it.
  logic [31:0] mem      [0:16383];
  int unsigned wr_stamp [0:16383];
  logic [15:0] log_addr [$];
  logic [7:0]  log_len  [$];
  int unsigned aw_count = 0;

  // AXI write slave, acting on the negative edge: a handshake seen here is
  // certain to complete at the following rising edge.
  initial begin
    logic [15:0] s_addr;
    int unsigned s_len, s_beat, b_delay, widx;
    bit          b_pend, hs_b;
    logic [1:0]  b_resp_pend;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bid = 8'h00;
    s_addr = '0; s_len = 0; s_beat = 0; b_delay = 0; b_pend = 0; hs_b = 0;
    b_resp_pend = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        b_pend = 0; hs_b = 0; s_beat = 0;
        continue;
      end
      if (hs_b) begin
        m_axi_bvalid = 1'b0;
        hs_b = 0;
      end
      if (b_pend && !m_axi_bvalid) begin
        if (b_delay == 0) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = b_resp_pend;
          b_pend       = 0;
        end else b_delay--;
      end
      if (m_axi_bvalid && m_axi_bready) hs_b = 1;
      if (m_axi_awvalid || m_axi_wvalid)
        check("aw_w_exclusive", 64'(m_axi_awvalid & m_axi_wvalid), 64'(0));
      m_axi_awready = ($urandom_range(99) >= stall_pct);
      if (m_axi_awvalid && m_axi_awready) begin
        log_addr.push_back(m_axi_awaddr);
        log_len.push_back(m_axi_awlen);
        aw_count++;
        check("awburst", 64'(m_axi_awburst), 64'(2'b01));
        check("awsize", 64'(m_axi_awsize), 64'(3'd2));
        check("awid", 64'(m_axi_awid), 64'(0));
        s_addr = m_axi_awaddr; s_len = 32'(m_axi_awlen); s_beat = 0;
      end
      m_axi_wready = ($urandom_range(99) >= stall_pct);
      if (m_axi_wvalid && m_axi_wready) begin
        widx = ((32'(s_addr) >> 2) + s_beat) % 16384;
        mem[widx]      = m_axi_wdata;
        wr_stamp[widx] = cur_seq;
        check("wlast", 64'(m_axi_wlast), 64'(s_beat == s_len));
        check("wstrb", 64'(m_axi_wstrb), 64'(4'hF));
        if (s_beat == s_len) begin
          b_pend      = 1;
          b_delay     = (stall_pct != 0) ? $urandom_range(4) : 0;
          b_resp_pend = ((int'(aw_count) - 1) == err_abs) ? 2'b10 : 2'b00;
        end
        s_beat++;
      end
    end
  end

  // Issue one command and compare bursts, data and status to the model.
  task automatic run_cmd(input logic [15:0] addr, input logic [15:0] len,
                         input logic [31:0] pat, input logic incr, input int eb);
    logic [15:0] ea [$];
    logic [7:0]  el [$];
    int unsigned a, a0, r, b, to4k, log_base, idx;
    logic [31:0] exp_w;
    logic        exp_err;
    bit          got;
    a0 = 32'(addr) & 32'hFFFC;
    a  = a0;
    r  = 32'(len);
    while (r != 0) begin
      to4k = (4096 - (a % 4096)) / 4;
      b = r;
      if (b > 16) b = 16;
      if (b > to4k) b = to4k;
      ea.push_back(16'(a));
      el.push_back(8'(b - 1));
      a = (a + 4 * b) % 65536;
      r = r - b;
    end
    exp_err  = (eb >= 0) && (eb < int'(ea.size()));
    cur_seq++;
    log_base = log_addr.size();
    err_abs  = (eb >= 0) ? int'(aw_count) + eb : -1;
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_pattern = pat; cmd_incr = incr;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (len == 16'd0) begin
      check("len0_done", 64'(done), 64'(1));
      check("len0_err", 64'(err), 64'(0));
      check("len0_busy", 64'(busy), 64'(0));
      for (int i = 0; i < 3; i++) begin
        check("len0_no_awvalid", 64'(m_axi_awvalid), 64'(0));
        @(negedge clk);
        check("len0_done_pulse", 64'(done), 64'(0));
      end
      check("len0_no_bursts", 64'(log_addr.size() - log_base), 64'(0));
      return;
    end
    check("accept_busy", 64'(busy), 64'(1));
    check("accept_awvalid", 64'(m_axi_awvalid), 64'(1));
    check("accept_awaddr", 64'(m_axi_awaddr), 64'(ea[0]));
    check("accept_awlen", 64'(m_axi_awlen), 64'(el[0]));
    cmd_valid = 1'b1; cmd_addr = 16'($urandom); cmd_len = 16'd5;
    check("busy_cmd_ready", 64'(cmd_ready), 64'(0));
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 64'(got), 64'(1));
    if (got) begin
      check("done_err", 64'(err), 64'(exp_err));
      check("done_busy", 64'(busy), 64'(0));
      check("done_cmd_ready", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      check("done_pulse", 64'(done), 64'(0));
    end
    check("burst_count", 64'(log_addr.size() - log_base), 64'(ea.size()));
    for (int i = 0; i < int'(ea.size()); i++) begin
      if (log_base + i < log_addr.size()) begin
        check($sformatf("awaddr[%0d]", i), 64'(log_addr[log_base + i]), 64'(ea[i]));
        check($sformatf("awlen[%0d]", i), 64'(log_len[log_base + i]), 64'(el[i]));
      end
    end
    for (int k = 0; k < int'(len); k++) begin
      idx   = ((a0 + 4 * k) % 65536) / 4;
      exp_w = pat + (incr ? 32'(k) : 32'd0);
      check($sformatf("written[%0h]", idx), 64'(wr_stamp[idx]), 64'(cur_seq));
      check($sformatf("data[%0h]", idx), 64'(mem[idx]), 64'(exp_w));
    end
    idx = ((a0 + 4 * 32'(len)) % 65536) / 4;
    check("beyond_region", 64'(wr_stamp[idx] == cur_seq), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int eb;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_pattern = '0; cmd_incr = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      wr_stamp[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
    check("rst_wvalid", 64'(m_axi_wvalid), 64'(0));
    check("rst_wlast", 64'(m_axi_wlast), 64'(0));
    check("rst_bready", 64'(m_axi_bready), 64'(0));
    rst = 1'b0;

    stall_pct = 0;
    run_cmd(16'h0100, 16'd4, 32'hA5A5_A5A5, 1'b0, -1);
    run_cmd(16'h0000, 16'd40, 32'h0000_0000, 1'b1, -1);
    run_cmd(16'h0FF8, 16'd4, $urandom, 1'b1, -1);
    run_cmd(16'h0123, 16'd0, $urandom, 1'b1, -1);
    run_cmd(16'hFFF8, 16'd4, 32'hFFFF_FFFE, 1'b1, -1);
    run_cmd(16'h0303, 16'd3, $urandom, 1'b1, -1);

    stall_pct = 40;
    run_cmd(16'h0400, 16'd40, $urandom, 1'b1, 1);
    run_cmd(16'h0800, 16'd20, $urandom, 1'b0, 0);
    for (int n = 0; n < 8; n++) begin
      eb = ($urandom_range(2) == 0) ? int'($urandom_range(3)) : -1;
      run_cmd(16'($urandom), 16'($urandom_range(50, 1)), $urandom, 1'($urandom), eb);
    end

    // Asynchronous reset in the middle of a 16-beat burst.
    stall_pct = 0;
    cur_seq++;
    err_abs = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 16'h0200; cmd_len = 16'd16;
    cmd_pattern = $urandom; cmd_incr = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      if (m_axi_wvalid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst_test_reached_w", 64'(got), 64'(1));
    @(negedge clk);
    @(negedge clk);
    check("rst_test_in_w", 64'(m_axi_wvalid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_awvalid", 64'(m_axi_awvalid), 64'(0));
    check("midrst_wvalid", 64'(m_axi_wvalid), 64'(0));
    check("midrst_wlast", 64'(m_axi_wlast), 64'(0));
    check("midrst_bready", 64'(m_axi_bready), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("postrst_done", 64'(done), 64'(0));
    run_cmd(16'h0200, 16'd16, $urandom, 1'b1, -1);
    stall_pct = 30;
    run_cmd(16'h1FC0, 16'd33, $urandom, 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
